// File: rtl/fmul_scheduler.sv
// rtl/fmul_scheduler.sv - in-order issue scheduler for the shared FP multiply unit
`timescale 1ns/1ps
module fmul_scheduler #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_op1,
  input  logic [31:0] i_req_op2,
  input  logic [3:0]  i_req_wa3,
  output logic        o_req_ready,
  input  logic [3:0]  i_src_a1,
  input  logic [3:0]  i_src_a2,
  input  logic [3:0]  i_src_a3,
  output logic        o_hazard,
  output logic        o_unit_start,
  output logic [31:0] o_unit_op1,
  output logic [31:0] o_unit_op2,
  output logic [3:0]  o_unit_wa3,
  input  logic        i_unit_busy,
  input  logic        i_unit_done,
  input  logic        i_unit_fast,
  input  logic [31:0] i_unit_result,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_result,
  output logic [3:0]  o_wb_wa3,
  input  logic        i_wb_ack,
  output logic        o_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_q_op1 [DEPTH];
  logic [31:0]       r_q_op2 [DEPTH];
  logic [3:0]        r_q_wa3 [DEPTH];
  logic [DEPTH-1:0]  r_q_vld;
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [3:0]        r_if_wa3;
  logic [31:0]       r_wb_result;
  logic [3:0]        r_wb_wa3;
  logic [TW-1:0]     r_tmr;
  logic              r_error;

  logic              w_push, w_pop, w_start, w_timeout, w_hazard;
  logic [CW-1:0]     w_count_nxt;

  assign w_push      = i_req_valid && (r_count < CW'(DEPTH));
  assign w_start     = (r_state == S_ISSUE) && !i_unit_busy;
  assign w_pop       = w_start;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_timeout   = (r_state == S_WAIT) && !i_unit_done && (r_tmr == TW'(TIMEOUT - 1));

  // Queue payload needs no reset: r_q_vld and the pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_op1[r_wr_ptr] <= i_req_op1;
      r_q_op2[r_wr_ptr] <= i_req_op2;
      r_q_wa3[r_wr_ptr] <= i_req_wa3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_q_vld     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_if_wa3    <= '0;
      r_wb_result <= '0;
      r_wb_wa3    <= '0;
      r_tmr       <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_q_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_q_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_start) begin
        r_if_wa3 <= r_q_wa3[r_rd_ptr];
        r_tmr    <= '0;
        if (i_unit_fast) begin
          r_wb_result <= i_unit_result;
          r_wb_wa3    <= r_q_wa3[r_rd_ptr];
        end
      end
      if (r_state == S_WAIT) begin
        if (i_unit_done) begin
          r_wb_result <= i_unit_result;
          r_wb_wa3    <= r_if_wa3;
        end else begin
          r_tmr <= r_tmr + TW'(1);
        end
      end
      if (w_timeout) begin
        r_error  <= 1'b1;
        r_if_wa3 <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_unit_start = 1'b0;
    o_unit_op1   = '0;
    o_unit_op2   = '0;
    o_unit_wa3   = '0;
    o_wb_valid   = 1'b0;
    o_wb_result  = '0;
    o_wb_wa3     = '0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_unit_start = w_start;
        o_unit_op1   = r_q_op1[r_rd_ptr];
        o_unit_op2   = r_q_op2[r_rd_ptr];
        o_unit_wa3   = r_q_wa3[r_rd_ptr];
        if (w_start) w_state_nxt = i_unit_fast ? S_HOLD : S_WAIT;
      end
      S_WAIT: begin
        if (i_unit_done)    w_state_nxt = S_HOLD;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_HOLD: begin
        o_wb_valid  = 1'b1;
        o_wb_result = r_wb_result;
        o_wb_wa3    = r_wb_wa3;
        // Count after any same-cycle push decides whether to go straight back to issue.
        if (i_wb_ack) w_state_nxt = (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  function automatic logic f_hit(input logic [3:0] d);
    return (d == i_src_a1) || (d == i_src_a2) || (d == i_src_a3) ||
           (i_req_valid && (d == i_req_wa3));
  endfunction

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_vld[i] && f_hit(r_q_wa3[i])) w_hazard = 1'b1;
    end
    if ((r_state == S_WAIT) && f_hit(r_if_wa3)) w_hazard = 1'b1;
    if ((r_state == S_HOLD) && f_hit(r_wb_wa3)) w_hazard = 1'b1;
  end

  assign o_hazard    = w_hazard;
  assign o_req_ready = (r_count < CW'(DEPTH));
  assign o_error     = r_error;

endmodule
